pe_array_sequencer: RTL and testbench

PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

---
 rtl/pe_array_sequencer.sv | 121 ++++++++++++
 tb/tb_pe_array_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_sequencer.sv
// Sequencer that walks a PE array through LOAD, then MAC / shift-A-left / shift-B-up rounds.
// Every command holds until the array acknowledges it with a two-cycle ready/ack exchange.
module pe_array_sequencer #(
   parameter int unsigned STEP_W        = 8,
   parameter int unsigned ARRAY_SIZE_1D = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [STEP_W-1:0] num_steps,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_count,
   output logic [2:0]        command_to_execute,
   output logic [1:0]        shift_direction,
   input  logic              array_ready,
   output logic              array_ack
);

   if (ARRAY_SIZE_1D < 1) begin : g_bad_size
      $error("ARRAY_SIZE_1D must be at least 1");
   end

   typedef enum logic [2:0] {StIdle, StLoad, StMac, StShlA, StShuB, StDone} state_t;

   state_t            r_state;
   state_t            w_adv_state;
   logic [STEP_W-1:0] r_num;
   logic [STEP_W-1:0] r_count;
   logic [2:0]        r_cmd;
   logic [1:0]        r_dir;
   logic              r_ack;
   logic              r_busy;
   logic              r_done;

   function automatic logic [2:0] cmd_of(state_t s);
      case (s)
         StLoad:         return 3'd1;
         StMac:          return 3'd2;
         StShlA, StShuB: return 3'd3;
         default:        return 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] dir_of(state_t s);
      return (s == StShlA) ? 2'd2 : 2'd0;
   endfunction

   // r_count already includes the MAC just accepted when the advance edge arrives.
   always_comb begin
      w_adv_state = StIdle;
      case (r_state)
         StLoad:  w_adv_state = (r_num == '0) ? StDone : StMac;
         StMac:   w_adv_state = (r_count == r_num) ? StDone : StShlA;
         StShlA:  w_adv_state = StShuB;
         StShuB:  w_adv_state = StMac;
         default: w_adv_state = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= StIdle;
         r_num   <= '0;
         r_count <= '0;
         r_cmd   <= '0;
         r_dir   <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != StIdle && abort) begin
            // Abort wins over any pending accept; step_count is left as is.
            r_state <= StIdle;
            r_cmd   <= '0;
            r_dir   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               StIdle: begin
                  if (start && !abort) begin
                     r_num   <= num_steps;
                     r_count <= '0;
                     r_state <= StLoad;
                     r_cmd   <= cmd_of(StLoad);
                     r_dir   <= dir_of(StLoad);
                     r_busy  <= 1'b1;
                  end
               end
               StDone: begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
               default: begin
                  if (r_ack) begin
                     r_ack   <= 1'b0;
                     r_state <= w_adv_state;
                     r_cmd   <= cmd_of(w_adv_state);
                     r_dir   <= dir_of(w_adv_state);
                     r_done  <= (w_adv_state == StDone);
                  end else if (array_ready) begin
                     r_ack <= 1'b1;
                     if (r_state == StMac) r_count <= r_count + STEP_W'(1);
                  end
               end
            endcase
         end
      end
   end

   assign busy               = r_busy;
   assign done               = r_done;
   assign step_count         = r_count;
   assign command_to_execute = r_cmd;
   assign shift_direction    = r_dir;
   assign array_ack          = r_ack;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Bench for pe_array_sequencer: vector table, directed corner sequences and a randomized run
// against a command-queue reference model.
module tb_pe_array_sequencer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       start;
   logic       abort;
   logic       array_ready;
   logic [7:0] num_steps;
   logic       busy;
   logic       done;
   logic [7:0] step_count;
   logic [2:0] command_to_execute;
   logic [1:0] shift_direction;
   logic       array_ack;

   pe_array_sequencer #(.STEP_W(8), .ARRAY_SIZE_1D(4)) dut (
      .CLK                (CLK),
      .RST                (RST),
      .start              (start),
      .num_steps          (num_steps),
      .abort              (abort),
      .busy               (busy),
      .done               (done),
      .step_count         (step_count),
      .command_to_execute (command_to_execute),
      .shift_direction    (shift_direction),
      .array_ready        (array_ready),
      .array_ack          (array_ack)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       st;
      logic       ab;
      logic       rdy;
      logic [7:0] num;
      logic [2:0] cmd;
      logic [1:0] dir;
      logic       ack;
      logic       bsy;
      logic       dn;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[12];

   // Reference model: pending command list (1 LOAD, 2 MAC, 3 SHL_A, 4 SHU_B).
   int m_seq[$];
   bit m_busy, m_ack, m_indone;
   int m_cnt;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(string name, logic [2:0] ecmd, logic [1:0] edir, logic eack,
                        logic ebusy, logic edone, logic [7:0] ecnt);
      n_tests++;
      if ({command_to_execute, shift_direction, array_ack, busy, done, step_count} !==
          {ecmd, edir, eack, ebusy, edone, ecnt}) begin
         n_fail++;
         $display("FAIL %s @%0t: got cmd=%0d dir=%0d ack=%0b busy=%0b done=%0b cnt=%0d, want cmd=%0d dir=%0d ack=%0b busy=%0b done=%0b cnt=%0d",
                  name, $time, command_to_execute, shift_direction, array_ack, busy, done,
                  step_count, ecmd, edir, eack, ebusy, edone, ecnt);
      end
   endtask

   task automatic check_int(string name, int got, int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_seq.delete();
      m_busy   = 0;
      m_ack    = 0;
      m_indone = 0;
      m_cnt    = 0;
   endtask

   // Applies the rules for one clock edge given the inputs currently driven.
   task automatic model_step();
      if (!m_busy) begin
         if (start && !abort) begin
            m_seq.delete();
            m_seq.push_back(1);
            for (int k = 0; k < int'(num_steps); k++) begin
               if (k > 0) begin
                  m_seq.push_back(3);
                  m_seq.push_back(4);
               end
               m_seq.push_back(2);
            end
            m_busy   = 1;
            m_cnt    = 0;
            m_ack    = 0;
            m_indone = 0;
         end
      end else if (abort) begin
         m_busy   = 0;
         m_ack    = 0;
         m_indone = 0;
         m_seq.delete();
      end else if (m_indone) begin
         m_busy   = 0;
         m_indone = 0;
      end else if (m_ack) begin
         m_ack = 0;
         void'(m_seq.pop_front());
         if (m_seq.size() == 0) m_indone = 1;
      end else if (array_ready) begin
         m_ack = 1;
         if (m_seq[0] == 2) m_cnt++;
      end
   endtask

   task automatic model_check(string name);
      logic [2:0] ecmd;
      logic [1:0] edir;
      ecmd = 3'd0;
      edir = 2'd0;
      if (m_busy && !m_indone && m_seq.size() > 0) begin
         ecmd = (m_seq[0] == 4) ? 3'd3 : 3'(m_seq[0]);
         edir = (m_seq[0] == 3) ? 2'd2 : 2'd0;
      end
      check(name, ecmd, edir, m_ack, m_busy, m_indone, 8'(m_cnt));
   endtask

   initial begin
      int acks[$];
      int exp_acks[8];
      int done_cyc;
      int cyc;
      bit found;

      RST = 1'b1; start = 1'b0; abort = 1'b0; array_ready = 1'b0; num_steps = 8'd0;
      tick();
      tick();
      check("reset_state", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      RST = 1'b0;

      // st ab rdy num | cmd dir ack busy done cnt
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'd0, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd0};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'd5, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'd5, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'd4, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'd0, 3'd1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd2, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd2, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 2'd2, 1'b0, 1'b1, 1'b0, 8'd1};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 8'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1};
      for (int i = 0; i < 12; i++) begin
         start = tbl[i].st; abort = tbl[i].ab; array_ready = tbl[i].rdy;
         num_steps = tbl[i].num;
         tick();
         check($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].dir, tbl[i].ack, tbl[i].bsy,
               tbl[i].dn, tbl[i].cnt);
      end
      start = 1'b0; abort = 1'b0;

      // Full job with ready tied high: command order, ack count and done timing.
      exp_acks = '{4, 8, 14, 12, 8, 14, 12, 8};
      array_ready = 1'b1; num_steps = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 2;
      done_cyc = -1;
      while (cyc <= 40) begin
         if (array_ack) acks.push_back(int'(command_to_execute) * 4 + int'(shift_direction));
         if (done) begin
            done_cyc = cyc;
            break;
         end
         tick();
         cyc++;
      end
      check_int("k3_done_cycle", done_cyc, 18);
      check_int("k3_ack_count", acks.size(), 8);
      for (int i = 0; i < 8; i++)
         check_int($sformatf("k3_cmd%0d", i), (i < acks.size()) ? acks[i] : -1, exp_acks[i]);
      check_int("k3_final_count", int'(step_count), 3);
      tick();
      check("k3_idle", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd3);

      // Ready low for five cycles during the first MAC.
      num_steps = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         if (command_to_execute == 3'd2) begin
            found = 1;
            break;
         end
         tick();
      end
      check_int("stall_reach_mac", int'(found), 1);
      array_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("stall_hold%0d", i), 3'd2, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      end
      array_ready = 1'b1;
      tick();
      check("stall_accept", 3'd2, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1);
      tick();
      check("stall_advance", 3'd3, 2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Asynchronous reset while ack is high in MAC.
      num_steps = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (command_to_execute == 3'd2 && array_ack) begin
            found = 1;
            break;
         end
         tick();
      end
      check_int("rst_reach_mac_ack", int'(found), 1);
      #2 RST = 1'b1;
      #1 check("rst_async", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      start = 1'b1;
      tick();
      RST = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_wait%0d", i), 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      end

      // Randomized traffic against the reference model.
      model_reset();
      for (int i = 0; i < 4000; i++) begin
         start       = ($urandom_range(0, 7) == 0);
         abort       = ($urandom_range(0, 59) == 0);
         array_ready = ($urandom_range(0, 9) < 7);
         num_steps   = 8'($urandom_range(0, 6));
         model_step();
         tick();
         model_check("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
